// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - picoMIPS program-memory boot/reload controller
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_last,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              cpu_stop,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {HALT, LOAD, FLUSH, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= HALT;
      ld_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      ptr       <= '0;
      last      <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        HALT, RUN: begin
          // A reload request takes priority over a stop request.
          if (ld_start) begin
            state    <= LOAD;
            ptr      <= '0;
            checksum <= '0;
            last     <= ld_last;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_run  <= 1'b0;
          end else if (state == RUN && cpu_stop) begin
            state   <= HALT;
            cpu_run <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_valid && ld_ready) begin
            mem_we    <= 1'b1;
            mem_waddr <= ptr;
            mem_wdata <= ld_data;
            checksum  <= checksum ^ ld_data;
            ptr       <= ptr + ADDR_W'(1);
            if (ptr == last) begin
              state    <= FLUSH;
              ld_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // The final word is on the write port this cycle; release next.
          state   <= RUN;
          busy    <= 1'b0;
          cpu_run <= 1'b1;
          done    <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot and reload controller for the picoMIPS program memory. Holds the processor halted after reset, accepts a stream of instruction words over a valid/ready handshake, writes them to consecutive program-memory addresses from 0, then releases the processor. A new load can be requested while the processor runs; the processor is halted for the whole load and restarted only after the final word has been written.

## Interface
Parameters:
- `ADDR_W`, default 6: program-memory address width.
- `DATA_W`, default 13: instruction width, {opcode, reg1, reg2, branch}.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `ld_start`  in  1  request a load session; sampled in HALT and RUN only.
- `ld_last`  in  ADDR_W  last address to write, sampled together with `ld_start`. Session writes `ld_last`+1 words.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  DATA_W  loader word.
- `ld_ready`  out  1  block accepts a word this cycle.
- `cpu_stop`  in  1  request to halt the processor; sampled in RUN only.
- `mem_we`  out  1  program-memory write enable.
- `mem_waddr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_run`  out  1  1 = processor may execute; 0 = processor held.
- `busy`  out  1  1 while in LOAD or FLUSH.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `checksum`  out  DATA_W  XOR of all words accepted in the most recent session.

## Operation
- States: HALT, LOAD, FLUSH, RUN. All outputs registered or decoded from state only (Moore); no combinational input-to-output path.
- Reset (`n_reset`=0, asynchronous): state HALT; `ld_ready`, `mem_we`, `cpu_run`, `busy`, `done` = 0; `mem_waddr`, `mem_wdata`, `checksum`, internal write pointer and stored `ld_last` = 0.
- HALT: `ld_start`=1 → LOAD; pointer ← 0, `checksum` ← 0, store `ld_last`.
- LOAD: `ld_ready`=1. Handshake = `ld_valid` & `ld_ready`. On handshake: `mem_waddr` ← pointer, `mem_wdata` ← `ld_data`, `mem_we` ← 1 for the next cycle, `checksum` ← `checksum` ^ `ld_data`, pointer ← pointer+1. With no handshake, `mem_we` ← 0 and the pointer holds. A handshake when pointer = stored `ld_last` → FLUSH. `ld_start` and `cpu_stop` are ignored.
- FLUSH: `ld_ready`=0, `mem_we`=1 for the final word. Next state RUN.
- RUN: `cpu_run`=1, `ld_ready`=0, `mem_we`=0. `ld_start`=1 → LOAD, same actions as in HALT. Otherwise `cpu_stop`=1 → HALT. Both asserted: `ld_start` wins.
- `ld_last`=0: a one-word session. `ld_last`=2^ADDR_W−1: a full-memory session. The pointer never wraps inside a session.
- `checksum` holds its value outside LOAD. It is only meaningful after `done`.
- `busy` = state is LOAD or FLUSH.

## Timing
- Handshake in cycle N → `mem_we`=1 with matching addr/data in cycle N+1.
- Sustained `ld_valid` gives one word per cycle.
- Last handshake in cycle N: FLUSH in N+1 (last write visible); RUN in N+2 with `cpu_run`=1 and `done`=1 for that cycle only.
- Minimum session with `ld_valid` held high and `ld_start` at cycle 0: LOAD at 1, first handshake at 1, `cpu_run` at `ld_last`+3.
- `ld_start` in RUN at cycle N: `cpu_run`=0 from N+1. `cpu_run` and `mem_we` are never 1 in the same cycle.
- `cpu_stop` in RUN at N: `cpu_run`=0 from N+1.
- Reset asserted mid-session: all outputs return to reset values immediately. The partially written memory is left as is, and the processor stays held until a new session completes.

## Test plan
- Reset, then `ld_start` with `ld_last`=1, words 0x0049 and 0x1A41 on consecutive cycles → writes (0,0x0049), (1,0x1A41); `checksum`=0x1A08; `done` pulse and `cpu_run`=1 exactly 2 cycles after the last handshake.
- `ld_last`=3 with `ld_valid` toggling 1,0,1,0,… → exactly 4 writes at addresses 0..3, with no write in cycles lacking a handshake.
- `ld_last`=0, single word 0x1FFF → one write at address 0; `checksum`=0x1FFF; RUN reached.
- `ld_last`=63 full load, then `ld_start` with `ld_last`=0 in RUN → `cpu_run` drops the next cycle; new session restarts at address 0; `checksum` restarts from 0.
- In RUN, `cpu_stop` alone → HALT with `cpu_run`=0 next cycle. In RUN, `cpu_stop` and `ld_start` together → LOAD, `busy`=1.
- `n_reset` pulsed low between words of a 4-word session → `mem_we`, `ld_ready`, `busy`, `checksum` = 0 immediately; state HALT; `ld_valid` ignored until the next `ld_start`.
